// File: rtl/serial_fullass_ctrl.sv
// serial_fullass_ctrl: bit-serial N-bit adder reusing one full-adder cell, LSB first,
// with valid/ready handshakes on operands and result.
module fullass (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_fullass_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow,
  output logic         busy
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] a_sh, b_sh, sum_sh;
  logic carry, prev_carry, fa_sum, fa_cout;
  logic [CW-1:0] cnt;
  fullass u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(fa_sum), .cout(fa_cout));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      carry <= 1'b0;
      prev_carry <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            carry <= carry_in;
            cnt <= '0;
            state <= RUN;
          end
        RUN: begin
          sum_sh <= {fa_sum, sum_sh[N-1:1]};
          carry <= fa_cout;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          // cnt parks at N-1 on the last bit so it never wraps
          if (cnt == CW'(N - 1)) begin
            prev_carry <= carry;
            state <= DONE;
          end else
            cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
  // after the last bit, carry holds the MSB carry-out and prev_carry the carry into the MSB
  assign sum = sum_sh;
  assign carry_out = carry;
  assign overflow = prev_carry ^ carry;
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_serial_fullass_ctrl.sv
// tb_serial_fullass_ctrl: directed checks of the serial adder against an arithmetic model,
// plus an exhaustive sweep on a 2-bit instance.
module tb_serial_fullass_ctrl;
  localparam int N = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0, carry_in = 0;
  logic [N-1:0] a = '0, b = '0;
  logic in_ready, out_valid, carry_out, overflow, busy;
  logic [N-1:0] sum;
  logic iv2 = 0, or2 = 1, c2 = 0;
  logic [1:0] a2 = '0, b2 = '0;
  logic ir2, ov2, co2, of2, bz2;
  logic [1:0] s2;
  int errors = 0, checks = 0;
  logic [N-1:0] exp_sum;
  logic exp_cout, exp_ovf;

  serial_fullass_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );
  serial_fullass_ctrl #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .carry_in(c2), .out_valid(ov2), .out_ready(or2), .sum(s2),
    .carry_out(co2), .overflow(of2), .busy(bz2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    {exp_cout, exp_sum} = {1'b0, x} + {1'b0, y} + (N+1)'(c);
    exp_ovf = (x[N-1] == y[N-1]) && (exp_sum[N-1] != x[N-1]);
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk("ready_valid_exclusive", in_ready & out_valid, 0);
      chk("busy_vs_ready", busy, !in_ready);
      if (out_valid) begin
        chk("model_sum", sum, exp_sum);
        chk("model_cout", carry_out, exp_cout);
        chk("model_ovf", overflow, exp_ovf);
      end
    end

  task automatic wait_done(input string name);
    int k = 0;
    while (!out_valid && k < N + 4) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, k, N);
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                        input int hold, input logic [N-1:0] es, input logic ec, input logic eo);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", in_ready, 1);
    a = x; b = y; carry_in = c; in_valid = 1; out_ready = 0;
    model(x, y, c);
    @(posedge clk); #1;
    in_valid = 0;
    chk("run_not_ready", in_ready, 0);
    wait_done("latency");
    chk("lit_sum", sum, es);
    chk("lit_cout", carry_out, ec);
    chk("lit_ovf", overflow, eo);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_handoff", in_ready, 1);
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y, input logic c);
    logic [1:0] es;
    logic ec, eo;
    int k = 0;
    @(negedge clk);
    a2 = x; b2 = y; c2 = c; iv2 = 1;
    {ec, es} = {1'b0, x} + {1'b0, y} + 3'(c);
    eo = (x[1] == y[1]) && (es[1] != x[1]);
    @(posedge clk); #1;
    iv2 = 0;
    while (!ov2 && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    chk("n2_latency", k, 2);
    chk("n2_sum", s2, es);
    chk("n2_cout", co2, ec);
    chk("n2_ovf", of2, eo);
    @(posedge clk); #1;
    chk("n2_idle", ir2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_sum", sum, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready_held", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("reset_release_ready", in_ready, 1);
    run_op(8'h2B, 8'h17, 0, 0, 8'h42, 0, 0);
    run_op(8'hFF, 8'h00, 1, 0, 8'h00, 1, 0);
    run_op(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    run_op(8'h80, 8'h80, 0, 0, 8'h00, 1, 1);
    run_op(8'hC3, 8'h5A, 1, 2, 8'h1E, 1, 0);
    // backpressure with new operands pushed throughout RUN and DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; carry_in = 0; in_valid = 1;
    model(8'h10, 8'h20, 0);
    @(posedge clk); #1;
    a = 8'h55; b = 8'h66; carry_in = 1;
    wait_done("bp_latency");
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_ready_low", in_ready, 0);
      chk("bp_valid_high", out_valid, 1);
      chk("bp_sum_stable", sum, 8'h30);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_back_idle", in_ready, 1);
    model(8'h55, 8'h66, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_second_accept", busy, 1);
    wait_done("bp2_latency");
    chk("bp2_sum", sum, 8'hBC);
    chk("bp2_cout", carry_out, 0);
    chk("bp2_ovf", overflow, 1);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    // asynchronous reset at cnt==3
    @(negedge clk);
    a = 8'h07; b = 8'h00; carry_in = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst = 1;
    #1;
    chk("async_sum", sum, 0);
    chk("async_cout", carry_out, 0);
    chk("async_ovf", overflow, 0);
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_reset_ready", in_ready, 1);
    run_op(8'h01, 8'h02, 0, 0, 8'h03, 0, 0);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          run2(2'(x), 2'(y), 1'(c));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
